seq_bit_serializer: RTL and testbench

//   Parallel-to-serial front end for the bit-sequence detector FSM.

---
 rtl/seq_bit_serializer_if.sv | 23 ++
 rtl/seq_bit_serializer.sv | 131 +++++++++++++
 tb/tb_seq_bit_serializer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out handshake bundle for the serializer.
interface seq_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] pdata;
  logic             pvalid;
  logic             pready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;
  logic [15:0]      word_cnt;

  modport master (
    output pdata, pvalid,
    input  pready, sout, sout_valid, sout_last, busy, word_cnt
  );

  modport slave (
    input  pdata, pvalid,
    output pready, sout, sout_valid, sout_last, busy, word_cnt
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on valid/ready and
// streams them one bit per clock toward the sequence detector.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_bit_serializer_if.slave  bus
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       GAP_LAST = 8'(GAP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPW} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             sout_last_q, sout_last_d;
  logic             busy_q, busy_d;
  logic             pready_c;
  logic             accept_c;

  // The bit on the wire always sits at a fixed end of the shift register.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready depends only on state so pvalid can never loop back into it.
  always_comb begin
    pready_c = !rst && ((state_q == IDLE) ||
                        ((state_q == SHIFT) && (bit_cnt_q == LAST_IDX) && (GAP == 0)));
    accept_c = bus.pvalid && pready_c;
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    word_cnt_d = word_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d   = SHIFT;
          shreg_d   = bus.pdata;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_IDX) begin
          if (accept_c) begin
            shreg_d   = bus.pdata;
            bit_cnt_d = '0;
          end else if (GAP != 0) begin
            state_d   = GAPW;
            gap_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shreg_d   = advance(shreg_q);
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      GAPW: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end

    // Outputs are registered views of the state being entered.
    sout_valid_d = (state_d == SHIFT);
    sout_d       = (state_d == SHIFT) ? head_bit(shreg_d) : IDLE_BIT;
    sout_last_d  = (state_d == SHIFT) && (bit_cnt_d == LAST_IDX);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      word_cnt_q   <= '0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      word_cnt_q   <= word_cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.pready     = pready_c;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.sout_last  = sout_last_q;
  assign bus.busy       = busy_q;
  assign bus.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench: three serializer configurations checked cycle by cycle
// against an expected per-cycle trace derived from the word list.
module tb_seq_bit_serializer;

  localparam int unsigned W    = 8;
  localparam int          NDUT = 3;

  // Instance configurations: 0 = MSB first/no gap, 1 = MSB first/GAP 2, 2 = LSB first/idle high.
  function automatic int gap_of(input int k);
    return (k == 1) ? 2 : 0;
  endfunction
  function automatic logic msb_of(input int k);
    return (k != 2);
  endfunction
  function automatic logic idle_of(input int k);
    return (k == 2);
  endfunction

  typedef struct {
    logic v;  // sout_valid
    logic b;  // sout
    logic l;  // sout_last
    logic r;  // pready
    logic y;  // busy
  } ent_t;

  logic         clk;
  logic         rst;
  logic         pv     [NDUT];
  logic [W-1:0] pd     [NDUT];
  logic         o_sout [NDUT];
  logic         o_v    [NDUT];
  logic         o_l    [NDUT];
  logic         o_r    [NDUT];
  logic         o_b    [NDUT];
  logic [15:0]  o_cnt  [NDUT];
  logic [15:0]  exp_cnt[NDUT];

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(W)) if0 ();
  seq_bit_serializer_if #(.WIDTH(W)) if1 ();
  seq_bit_serializer_if #(.WIDTH(W)) if2 ();

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b0))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(2), .IDLE_BIT(1'b0))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(0), .IDLE_BIT(1'b1))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  assign if0.pvalid = pv[0];
  assign if0.pdata  = pd[0];
  assign if1.pvalid = pv[1];
  assign if1.pdata  = pd[1];
  assign if2.pvalid = pv[2];
  assign if2.pdata  = pd[2];

  assign o_sout[0] = if0.sout;  assign o_v[0] = if0.sout_valid; assign o_l[0] = if0.sout_last;
  assign o_r[0]    = if0.pready; assign o_b[0] = if0.busy;      assign o_cnt[0] = if0.word_cnt;
  assign o_sout[1] = if1.sout;  assign o_v[1] = if1.sout_valid; assign o_l[1] = if1.sout_last;
  assign o_r[1]    = if1.pready; assign o_b[1] = if1.busy;      assign o_cnt[1] = if1.word_cnt;
  assign o_sout[2] = if2.sout;  assign o_v[2] = if2.sout_valid; assign o_l[2] = if2.sout_last;
  assign o_r[2]    = if2.pready; assign o_b[2] = if2.busy;      assign o_cnt[2] = if2.word_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic check_ent(input int k, input string ph, input ent_t e);
    chk($sformatf("d%0d %s sout_valid", k, ph), 16'(o_v[k]),    16'(e.v));
    chk($sformatf("d%0d %s sout",       k, ph), 16'(o_sout[k]), 16'(e.b));
    chk($sformatf("d%0d %s sout_last",  k, ph), 16'(o_l[k]),    16'(e.l));
    chk($sformatf("d%0d %s pready",     k, ph), 16'(o_r[k]),    16'(e.r));
    chk($sformatf("d%0d %s busy",       k, ph), 16'(o_b[k]),    16'(e.y));
    chk($sformatf("d%0d %s word_cnt",   k, ph), o_cnt[k],       exp_cnt[k]);
  endtask

  // While rst is high every instance must show its quiescent outputs.
  task automatic check_reset_all(input string ph);
    ent_t e;
    for (int k = 0; k < NDUT; k++) begin
      e = '{1'b0, idle_of(k), 1'b0, 1'b0, 1'b0};
      exp_cnt[k] = 16'h0000;
      check_ent(k, ph, e);
    end
  endtask

  // Presents words with pvalid held and checks the expected cycle trace.
  // abort_at >= 0 asserts rst mid-cycle right after that trace entry.
  task automatic run_stream(input int k, input logic [W-1:0] words[$], input int abort_at);
    ent_t         q[$];
    ent_t         e;
    ent_t         idle_e;
    ent_t         gap_e;
    logic [W-1:0] w;
    int           nw;
    int           nxt;
    nw     = words.size();
    nxt    = 0;
    idle_e = '{1'b0, idle_of(k), 1'b0, 1'b1, 1'b0};
    gap_e  = '{1'b0, idle_of(k), 1'b0, 1'b0, 1'b1};
    q.push_back(idle_e);
    for (int j = 0; j < nw; j++) begin
      w = words[j];
      for (int i = 0; i < int'(W); i++) begin
        e.v = 1'b1;
        e.b = msb_of(k) ? w[int'(W) - 1 - i] : w[i];
        e.l = (i == int'(W) - 1);
        e.r = (i == int'(W) - 1) && (gap_of(k) == 0);
        e.y = 1'b1;
        q.push_back(e);
      end
      for (int g = 0; g < gap_of(k); g++) q.push_back(gap_e);
      if (gap_of(k) > 0 || j == nw - 1) q.push_back(idle_e);
    end
    for (int c = 0; c < q.size(); c++) begin
      @(negedge clk);
      check_ent(k, $sformatf("c%0d", c), q[c]);
      if (q[c].r && nxt < nw) begin
        pv[k] = 1'b1;
        pd[k] = words[nxt];
        nxt++;
        exp_cnt[k] = exp_cnt[k] + 16'd1;
      end else begin
        pv[k] = (nxt < nw);
        pd[k] = W'($urandom);
      end
      if (c == abort_at) begin
        #2 rst = 1'b1;
        pv[k] = 1'b0;
        #1 check_reset_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        break;
      end
    end
    pv[k] = 1'b0;
  endtask

  initial begin
    #2000000;
    $error("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ws[$];
    int           n;
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      pv[k]      = 1'b0;
      pd[k]      = '0;
      exp_cnt[k] = 16'h0000;
    end
    #3 check_reset_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single 8'h99 word, MSB first.
    ws = {8'h99};
    run_stream(0, ws, -1);
    // Back-to-back words without a bubble.
    ws = {8'hA5, 8'h3C};
    run_stream(0, ws, -1);
    // Two idle gap cycles between words.
    ws = {8'hC3, 8'h5A};
    run_stream(1, ws, -1);
    // LSB first.
    ws = {8'h01};
    run_stream(2, ws, -1);
    // Reset in the middle of bit 4, then a fresh word.
    ws = {8'hFF};
    run_stream(0, ws, 4);
    ws = {8'h0F};
    run_stream(0, ws, -1);

    // Word counter wrap.
    force u_dut0.word_cnt_q = 16'hFFFF;
    #1 release u_dut0.word_cnt_q;
    exp_cnt[0] = 16'hFFFF;
    ws = {8'h96, 8'h6B};
    run_stream(0, ws, -1);

    // Random word bursts on every instance.
    for (int k = 0; k < NDUT; k++) begin
      for (int r = 0; r < 4; r++) begin
        n = int'($urandom_range(1, 4));
        ws = {};
        for (int j = 0; j < n; j++) ws.push_back(W'($urandom));
        run_stream(k, ws, -1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
